// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: state encodings and the NOP/valid convention.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;
  localparam int          WDOG_W      = 8;

endpackage

// File: rtl/fetch_wdog.sv
// Fetch watchdog: load/enable 8-bit up-counter, expires when the count reaches TIMEOUT.
module fetch_wdog
  import fetch_unit_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  logic [WDOG_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expire = (r_count == WDOG_W'(TIMEOUT));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: req/ack fetch from instruction memory into an instruction register,
// PC stall generation and a sticky fault for misaligned PCs, memory errors and timeouts.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter int                DATA_W  = 32,
  parameter int                TIMEOUT = 15,
  parameter logic [DATA_W-1:0] NOP     = DATA_W'(NOP_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              flush,
  input  logic              decode_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              pc_stall,
  output logic              fetch_fault
);

  fetch_state_t      r_state;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_instr;
  logic              r_valid;
  logic              r_fault;
  logic              r_drop;
  logic              w_expire;

  fetch_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (r_state == S_IDLE),
    .i_en     ((r_state == S_REQ) && !mem_ack),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_instr    <= NOP;
      r_valid    <= 1'b0;
      r_fault    <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_mem_addr <= pc_addr;
          if (pc_addr[1:0] != 2'b00) begin
            r_state <= S_FAULT;
            r_fault <= 1'b1;
          end else begin
            r_state   <= S_REQ;
            r_mem_req <= 1'b1;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_drop    <= 1'b0;
            if (mem_err) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
              r_instr <= NOP;
              r_valid <= 1'b0;
            end else if (r_drop) begin
              r_state <= S_IDLE;
            end else begin
              r_instr <= mem_rdata;
              r_valid <= 1'b1;
              r_state <= S_HOLD;
            end
          end else if (w_expire) begin
            r_mem_req <= 1'b0;
            r_drop    <= 1'b0;
            r_state   <= S_FAULT;
            r_fault   <= 1'b1;
            r_instr   <= NOP;
          end else if (flush) begin
            // an issued request cannot be retracted; remember to discard its data
            r_drop <= 1'b1;
          end
        end
        S_HOLD: begin
          if (flush) begin
            r_valid <= 1'b0;
            r_instr <= NOP;
            r_state <= S_IDLE;
          end else if (decode_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_FAULT;
        end
      endcase
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign fetch_fault = r_fault;

  // PC moves once per consumed word, and is free in IDLE while its owner redirects it
  assign pc_stall = !((r_state == S_HOLD) && decode_ready && !flush) &&
                    !((r_state == S_IDLE) && flush);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: handshake, stalls, flush/drop, timeout, faults, async reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_addr;
  logic        flush;
  logic        decode_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic [31:0] instr;
  logic        instr_valid;
  logic        pc_stall;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15), .NOP(32'h0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_addr      (pc_addr),
    .flush        (flush),
    .decode_ready (decode_ready),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .mem_err      (mem_err),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc_stall     (pc_stall),
    .fetch_fault  (fetch_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   {31'd0, mem_req},     32'd0);
    chk({tag, "_addr"},  mem_addr,             32'd0);
    chk({tag, "_instr"}, instr,                32'd0);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_stall"}, {31'd0, pc_stall},    32'd1);
    chk({tag, "_fault"}, {31'd0, fetch_fault}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; pc_addr = 32'h0; flush = 1'b0; decode_ready = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'h0; mem_err = 1'b0;
    #1;
    chk_reset("rst0");
    tick(); tick();

    // 1: basic fetch, ack in first REQ cycle, decode consumes immediately
    decode_ready = 1'b1;
    rst_n = 1'b1;
    tick();
    chk("t1_req",   {31'd0, mem_req},  32'd1);
    chk("t1_addr",  mem_addr,          32'h0);
    chk("t1_stall_req", {31'd0, pc_stall}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h2008_0005;
    tick();
    mem_ack = 1'b0;
    chk("t1_instr", instr,                32'h2008_0005);
    chk("t1_valid", {31'd0, instr_valid}, 32'd1);
    chk("t1_req_hold", {31'd0, mem_req},  32'd0);
    chk("t1_stall_go", {31'd0, pc_stall}, 32'd0);
    tick();
    pc_addr = 32'h4;
    chk("t1_valid_off", {31'd0, instr_valid}, 32'd0);
    chk("t1_stall_idle", {31'd0, pc_stall},   32'd1);

    // 2: decode back-pressure in HOLD; stray ack there is ignored
    decode_ready = 1'b0;
    tick();
    chk("t2_addr", mem_addr, 32'h4);
    chk("t2_req",  {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      chk("t2_instr", instr,                32'h1111_2222);
      chk("t2_valid", {31'd0, instr_valid}, 32'd1);
      chk("t2_stall", {31'd0, pc_stall},    32'd1);
      chk("t2_req",   {31'd0, mem_req},     32'd0);
      tick();
    end
    mem_ack = 1'b0;
    decode_ready = 1'b1;
    #1;
    chk("t2_stall_go", {31'd0, pc_stall}, 32'd0);
    tick();
    pc_addr = 32'h8;
    chk("t2_stall_idle", {31'd0, pc_stall},   32'd1);
    chk("t2_valid_off", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("t2_next_addr", mem_addr, 32'h8);

    // 3: flush one cycle after the request; late ack data must be discarded
    tick();
    flush = 1'b1; pc_addr = 32'h40;
    #1;
    chk("t3_stall_flush", {31'd0, pc_stall}, 32'd1);
    tick();
    flush = 1'b0;
    chk("t3_req_held", {31'd0, mem_req}, 32'd1);
    chk("t3_addr_held", mem_addr, 32'h8);
    tick(); tick();
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    chk("t3_valid", {31'd0, instr_valid}, 32'd0);
    chk("t3_req",   {31'd0, mem_req},     32'd0);
    chk("t3_instr", instr,                32'h1111_2222);
    tick();
    chk("t3_redirect", mem_addr, 32'h40);
    chk("t3_req2", {31'd0, mem_req}, 32'd1);

    // 4: timeout -- 16 REQ cycles without ack, then sticky fault
    for (int i = 0; i < 15; i++) begin
      chk("t4_wait_fault", {31'd0, fetch_fault}, 32'd0);
      tick();
    end
    chk("t4_last_req", {31'd0, mem_req}, 32'd1);
    chk("t4_no_fault_yet", {31'd0, fetch_fault}, 32'd0);
    tick();
    chk("t4_fault", {31'd0, fetch_fault}, 32'd1);
    chk("t4_req",   {31'd0, mem_req},     32'd0);
    chk("t4_instr", instr,                32'h0);
    chk("t4_stall", {31'd0, pc_stall},    32'd1);
    flush = 1'b1; mem_ack = 1'b1;
    #1;
    chk("t4_stall_flush", {31'd0, pc_stall}, 32'd1);
    tick();
    flush = 1'b0; mem_ack = 1'b0;
    chk("t4_sticky", {31'd0, fetch_fault}, 32'd1);
    chk("t4_valid",  {31'd0, instr_valid}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk_reset("t4_rst");

    // 5a: misaligned PC faults without issuing a request
    pc_addr = 32'h6;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_mis_fault", {31'd0, fetch_fault}, 32'd1);
    chk("t5_mis_req",   {31'd0, mem_req},     32'd0);
    tick();
    chk("t5_mis_sticky", {31'd0, fetch_fault}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_fault", {31'd0, fetch_fault}, 32'd0);

    // 5b: memory error on ack
    pc_addr = 32'h10;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_req", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_err = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0; mem_err = 1'b0;
    chk("t5_err_fault", {31'd0, fetch_fault}, 32'd1);
    chk("t5_err_valid", {31'd0, instr_valid}, 32'd0);
    chk("t5_err_instr", instr,                32'h0);
    rst_n = 1'b0;
    #1;

    // 6: asynchronous reset in the middle of a REQ cycle
    pc_addr = 32'h20;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_req", {31'd0, mem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_req",   {31'd0, mem_req}, 32'd0);
    chk("t6_async_instr", instr,            32'h0);
    chk("t6_async_addr",  mem_addr,         32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_restart_req",  {31'd0, mem_req}, 32'd1);
    chk("t6_restart_addr", mem_addr,         32'h20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
